// File: rtl/md_sequencer_if.sv
// Handshake bundle between the E-stage issue logic and the multiply/divide sequencer.
// It also carries the HI/LO read path and the D-stage stall request.
interface md_sequencer_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        D_md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val, D_md_use,
        input  busy, md_stall, md_rdata, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, D_md_use,
        output busy, md_stall, md_rdata, hi, lo
    );
endinterface

// File: rtl/md_sequencer.sv
// Fixed-latency multiply/divide sequencer that owns the architectural HI/LO registers.
// The result is computed at issue, held as pending, and committed when the latency expires.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave md
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [63:0] r_pending;
    logic [63:0] w_pending_nxt;
    logic        r_pend_wr;
    logic        w_pend_wr_nxt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;

    logic        w_signed_mul;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_udiv_a;
    logic [31:0] w_udiv_b;
    logic [31:0] w_uquo;
    logic [31:0] w_urem;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_result;
    logic [31:0] w_rdata;

    // Multiplier: a 64x64 product of the extended operands gives the correct low 64 bits
    // for both signed and unsigned forms.
    assign w_signed_mul = (md.md_op == OP_MULT);
    assign w_mul_a = w_signed_mul ? {{32{md.rs_val[31]}}, md.rs_val} : {32'd0, md.rs_val};
    assign w_mul_b = w_signed_mul ? {{32{md.rt_val[31]}}, md.rt_val} : {32'd0, md.rt_val};
    assign w_prod  = w_mul_a * w_mul_b;

    // Signed divide runs on magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    assign w_signed_div = (md.md_op == OP_DIV);
    assign w_a_neg      = w_signed_div & md.rs_val[31];
    assign w_b_neg      = w_signed_div & md.rt_val[31];
    assign w_div_zero   = (md.rt_val == 32'd0);
    assign w_abs_a      = w_a_neg ? (~md.rs_val + 32'd1) : md.rs_val;
    assign w_abs_b      = w_b_neg ? (~md.rt_val + 32'd1) : md.rt_val;
    assign w_udiv_a     = w_abs_a;
    assign w_udiv_b     = w_div_zero ? 32'd1 : w_abs_b;
    assign w_uquo       = w_udiv_a / w_udiv_b;
    assign w_urem       = w_udiv_a % w_udiv_b;
    assign w_quo        = (w_a_neg ^ w_b_neg) ? (~w_uquo + 32'd1) : w_uquo;
    assign w_rem        = w_a_neg ? (~w_urem + 32'd1) : w_urem;

    assign w_result = md.md_op[1] ? {w_rem, w_quo} : w_prod;

    // Next-state and datapath update selection for the IDLE/RUN sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        w_pend_wr_nxt = r_pend_wr;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (md.start) begin
                    case (md.md_op)
                        OP_MULT, OP_MULTU: begin
                            w_state_nxt   = ST_RUN;
                            w_cnt_nxt     = MULT_N;
                            w_pending_nxt = w_result;
                            w_pend_wr_nxt = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor still occupies the unit but never commits.
                            w_state_nxt   = ST_RUN;
                            w_cnt_nxt     = DIV_N;
                            w_pending_nxt = w_result;
                            w_pend_wr_nxt = ~w_div_zero;
                        end
                        OP_MTHI: w_hi_nxt = md.rs_val;
                        OP_MTLO: w_lo_nxt = md.rs_val;
                        default: w_state_nxt = ST_IDLE;
                    endcase
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = 4'd0;
                    w_pending_nxt = 64'd0;
                    w_pend_wr_nxt = 1'b0;
                    if (r_pend_wr) begin
                        w_hi_nxt = r_pending[63:32];
                        w_lo_nxt = r_pending[31:0];
                    end else begin
                        w_hi_nxt = r_hi;
                        w_lo_nxt = r_lo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = 4'd0;
                w_pend_wr_nxt = 1'b0;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_pending <= 64'd0;
            r_pend_wr <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_pend_wr <= w_pend_wr_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
        end
    end

    // Combinational HI/LO read port for MFHI/MFLO.
    always_comb begin
        w_rdata = 32'd0;
        case (md.md_op)
            OP_MFHI: w_rdata = r_hi;
            OP_MFLO: w_rdata = r_lo;
            default: w_rdata = 32'd0;
        endcase
    end

    assign md.busy     = (r_state == ST_RUN);
    assign md.md_stall = md.D_md_use & (md.busy | (md.start & ~md.md_op[2]));
    assign md.md_rdata = w_rdata;
    assign md.hi       = r_hi;
    assign md.lo       = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: expected HI/LO are queued at issue and compared at commit.
module tb_md_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    md_sequencer_if mif();

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issuing while the unit is occupied is a hazard-unit bug.
    always @(posedge clk) begin
        if (!reset && mif.start && mif.busy) begin
            errors++;
            $error("FAIL start_while_busy observed=1 expected=0");
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sq;
        int          sr;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            3'd2: begin
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            3'd3: return {a % b, a / b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic d_use,
                         input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        int   busy_cnt;
        int   stall_cnt;
        int   guard;
        e.tag = tag;
        e.hi  = ehi;
        e.lo  = elo;
        sb.push_back(e);
        @(negedge clk);
        mif.start    = 1'b1;
        mif.md_op    = op;
        mif.rs_val   = a;
        mif.rt_val   = b;
        mif.D_md_use = d_use;
        #1;
        stall_cnt = mif.md_stall ? 1 : 0;
        @(negedge clk);
        mif.start = 1'b0;
        #1;
        busy_cnt = 0;
        guard    = 0;
        while (mif.busy && guard < 40) begin
            busy_cnt++;
            if (mif.md_stall) stall_cnt++;
            guard++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n));
        chk({tag, "_stall_cycles"}, 64'(stall_cnt), d_use ? 64'(n + 1) : 64'd0);
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_hi"}, {32'd0, mif.hi}, {32'd0, e.hi});
            chk({e.tag, "_lo"}, {32'd0, mif.lo}, {32'd0, e.lo});
        end
        mif.D_md_use = 1'b0;
    endtask

    task automatic do_mt(input string tag, input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        mif.start    = 1'b1;
        mif.md_op    = op;
        mif.rs_val   = v;
        mif.D_md_use = 1'b1;
        #1;
        chk({tag, "_busy_issue"}, {63'd0, mif.busy}, 64'd0);
        chk({tag, "_stall_issue"}, {63'd0, mif.md_stall}, 64'd0);
        @(negedge clk);
        mif.start = 1'b0;
        mif.md_op = (op == 3'd4) ? 3'd6 : 3'd7;
        #1;
        chk({tag, "_readback"}, {32'd0, mif.md_rdata}, {32'd0, v});
        chk({tag, "_busy_after"}, {63'd0, mif.busy}, 64'd0);
        chk({tag, "_stall_after"}, {63'd0, mif.md_stall}, 64'd0);
        mif.D_md_use = 1'b0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rexp;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        mif.start    = 1'b0;
        mif.md_op    = 3'd0;
        mif.rs_val   = 32'd0;
        mif.rt_val   = 32'd0;
        mif.D_md_use = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_busy", {63'd0, mif.busy}, 64'd0);
        chk("reset_stall", {63'd0, mif.md_stall}, 64'd0);
        chk("reset_hi", {32'd0, mif.hi}, 64'd0);
        chk("reset_lo", {32'd0, mif.lo}, 64'd0);
        mif.D_md_use = 1'b0;

        do_op("mult_neg", 3'd0, 32'hFFFFFFFF, 32'd2, 5, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE);
        mif.md_op = 3'd6;
        #1;
        chk("mfhi_after_mult", {32'd0, mif.md_rdata}, {32'd0, 32'hFFFFFFFF});
        mif.md_op = 3'd0;
        #1;
        chk("rdata_zero_nonmf", {32'd0, mif.md_rdata}, 64'd0);

        do_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 1'b1, 32'h00000001, 32'hFFFFFFFE);
        mif.md_op = 3'd7;
        #1;
        chk("mflo_after_multu", {32'd0, mif.md_rdata}, {32'd0, 32'hFFFFFFFE});

        do_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b1, 32'h00000001, 32'h7FFFFFFC);
        do_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'h0, 32'h80000000);

        do_mt("mthi", 3'd4, 32'h12345678);
        do_mt("mthi_a", 3'd4, 32'h0000000A);
        do_mt("mtlo_b", 3'd5, 32'h0000000B);
        do_op("div_zero", 3'd2, 32'd55, 32'd0, 10, 1'b0, 32'h0000000A, 32'h0000000B);

        // Reset on the third cycle of a DIV discards the in-flight result.
        @(negedge clk);
        mif.start  = 1'b1;
        mif.md_op  = 3'd2;
        mif.rs_val = 32'd100;
        mif.rt_val = 32'd7;
        @(negedge clk);
        mif.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_run_busy", {63'd0, mif.busy}, 64'd0);
        chk("rst_run_hi", {32'd0, mif.hi}, 64'd0);
        chk("rst_run_lo", {32'd0, mif.lo}, 64'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        chk("rst_no_commit_hi", {32'd0, mif.hi}, 64'd0);
        chk("rst_no_commit_lo", {32'd0, mif.lo}, 64'd0);
        do_op("mult_3x4", 3'd0, 32'd3, 32'd4, 5, 1'b0, 32'd0, 32'd12);

        for (int i = 0; i < 8; i++) begin
            rop = 3'(i % 4);
            ra  = $urandom;
            rb  = $urandom;
            if (i >= 4) rb = rb >> $urandom_range(28, 0);
            if (rb == 32'd0) rb = 32'd3;
            rexp = model(rop, ra, rb);
            do_op("rand_op", rop, ra, rb, rop[1] ? 10 : 5, 1'(i % 2),
                  rexp[63:32], rexp[31:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
